// File: rtl/sinc3_decimator_if.sv
// Bitstream-in / PCM-out bundle of the sinc^3 decimator.
// The master side owns the bit-rate qualifier and the bitstream; the slave (the filter) returns samples.
interface sinc3_decimator_if #(
   parameter int OUT_W = 20
);
   logic                    clk_enable;
   logic                    bit_in;
   logic signed [OUT_W-1:0] filter_out;
   logic                    ce_out;

   modport master (
      output clk_enable,
      output bit_in,
      input  filter_out,
      input  ce_out
   );

   modport slave (
      input  clk_enable,
      input  bit_in,
      output filter_out,
      output ce_out
   );
endinterface

// File: rtl/sinc3_decimator.sv
// Third-order CIC decimator: 1-bit sigma-delta stream in, signed PCM out at 1/2^LOG2_DECIM of the bit rate.
// Integrators wrap modulo 2^ACC_W by design; the comb differences recover the exact result.
module sinc3_decimator #(
   parameter int LOG2_DECIM = 6,
   parameter int OUT_W      = 20
) (
   input  logic             clk,
   input  logic             reset,
   sinc3_decimator_if.slave bus
);
   localparam int ACC_W = 2 + 3 * LOG2_DECIM;
   localparam logic [LOG2_DECIM-1:0] DCNT_LAST = '1;

   typedef logic signed [ACC_W-1:0] acc_t;

   // The first three strobes only prime the comb delay line.
   typedef enum logic [1:0] {
      SETTLE0,
      SETTLE1,
      SETTLE2,
      RUN
   } settle_e;

   acc_t                    i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
   acc_t                    d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
   acc_t                    x, c1, c2, c3;
   logic [LOG2_DECIM-1:0]   dcnt_q, dcnt_d;
   settle_e                 state_q, state_d;
   logic signed [OUT_W-1:0] out_q, out_d, y;
   logic                    ce_q, ce_d;
   logic                    strobe;

   generate
      if (ACC_W >= OUT_W) begin : g_trunc
         acc_t c3_sh;
         assign c3_sh = c3 >>> (ACC_W - OUT_W);
         assign y     = c3_sh[OUT_W-1:0];
      end else begin : g_sext
         assign y = OUT_W'(c3);
      end
   endgenerate

   // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
   always_comb begin
      x      = bus.bit_in ? acc_t'(1) : acc_t'(-1);
      strobe = bus.clk_enable && (dcnt_q == DCNT_LAST);
      c1     = i3_q - d1_q;
      c2     = c1 - d2_q;
      c3     = c2 - d3_q;

      i1_d    = i1_q;
      i2_d    = i2_q;
      i3_d    = i3_q;
      d1_d    = d1_q;
      d2_d    = d2_q;
      d3_d    = d3_q;
      dcnt_d  = dcnt_q;
      state_d = state_q;
      out_d   = out_q;
      ce_d    = 1'b0;

      if (bus.clk_enable) begin
         i1_d   = i1_q + x;
         i2_d   = i2_q + i1_q;
         i3_d   = i3_q + i2_q;
         dcnt_d = dcnt_q + LOG2_DECIM'(1);
      end

      if (strobe) begin
         d1_d = i3_q;
         d2_d = c1;
         d3_d = c2;
         unique case (state_q)
            SETTLE0: state_d = SETTLE1;
            SETTLE1: state_d = SETTLE2;
            SETTLE2: state_d = RUN;
            RUN: begin
               out_d = y;
               ce_d  = 1'b1;
            end
            default: state_d = SETTLE0;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         i1_q    <= '0;
         i2_q    <= '0;
         i3_q    <= '0;
         d1_q    <= '0;
         d2_q    <= '0;
         d3_q    <= '0;
         dcnt_q  <= '0;
         state_q <= SETTLE0;
         out_q   <= '0;
         ce_q    <= 1'b0;
      end else begin
         i1_q    <= i1_d;
         i2_q    <= i2_d;
         i3_q    <= i3_d;
         d1_q    <= d1_d;
         d2_q    <= d2_d;
         d3_q    <= d3_d;
         dcnt_q  <= dcnt_d;
         state_q <= state_d;
         out_q   <= out_d;
         ce_q    <= ce_d;
      end
   end

   assign bus.filter_out = out_q;
   assign bus.ce_out     = ce_q;

endmodule

// File: tb/tb_sinc3_decimator.sv
// Directed bench for sinc3_decimator at the default 64x decimation and 20-bit output.
// Expected samples are hand-derived from the cubed 64-tap box filter (DC gain 262144).
module tb_sinc3_decimator;
   localparam int LOG2_DECIM = 6;
   localparam int OUT_W      = 20;
   localparam int G          = 262144;

   logic clk = 1'b0;
   logic reset;

   sinc3_decimator_if #(.OUT_W(OUT_W)) bus ();

   sinc3_decimator #(
      .LOG2_DECIM(LOG2_DECIM),
      .OUT_W     (OUT_W)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int   passed = 0;
   int   total  = 0;
   int   outs[$];
   int   out_edge[$];
   int   en_edges;
   int   width_err;
   int   frozen_err;
   logic last_en;
   logic ce_prev;

   // Step response: strobes 4..13 after reset, zeros until enabled edge 320, ones after.
   int step_exp[10] = '{-G, -G, -182722, 166340, 262142, G, G, G, G, G};

   // One clock: drive inputs, take the edge, sample outputs on the falling edge.
   task automatic cyc(input logic en, input logic b);
      bus.clk_enable = en;
      bus.bit_in     = b;
      @(posedge clk);
      if (en && !reset) en_edges++;
      last_en = en && !reset;
      @(negedge clk);
      if (bus.ce_out === 1'b1) begin
         if (ce_prev === 1'b1) width_err++;
         if (!last_en) frozen_err++;
         outs.push_back(int'(bus.filter_out));
         out_edge.push_back(en_edges);
      end
      ce_prev = bus.ce_out;
   endtask

   task automatic clear_log();
      outs.delete();
      out_edge.delete();
      en_edges   = 0;
      width_err  = 0;
      frozen_err = 0;
   endtask

   // mode 0: all ones, 1: all zeros, 2: alternating starting with 1
   task automatic feed(input int n, input int mode, input bit gated);
      for (int k = 0; k < n; k++) begin
         logic b;
         b = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : ~k[0];
         if (gated) begin
            while ($urandom_range(1, 0) == 0) cyc(1'b0, 1'($urandom_range(1, 0)));
         end
         cyc(1'b1, b);
      end
   endtask

   task automatic pulse_reset(input logic en);
      reset = 1'b1;
      cyc(en, 1'b1);
      reset = 1'b0;
   endtask

   task automatic check_outs(input string name, input int n, input int value);
      total++;
      if (outs.size() !== n) $display("FAIL %s_count: got %0d want %0d", name, outs.size(), n);
      else passed++;
      for (int i = 0; i < n; i++) begin
         total++;
         if (i >= outs.size()) $display("FAIL %s_val[%0d]: got none want %0d", name, i, value);
         else if (outs[i] !== value) $display("FAIL %s_val[%0d]: got %0d want %0d", name, i, outs[i], value);
         else passed++;
      end
      total++;
      if (width_err !== 0) $display("FAIL %s_ce_width: got %0d long pulses want 0", name, width_err);
      else passed++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int k = 0; k < 3; k++) cyc(1'b1, 1'($urandom_range(1, 0)));
      total++;
      if (bus.filter_out !== '0) $display("FAIL reset_filter_out: got %0d want 0", bus.filter_out);
      else passed++;
      total++;
      if (bus.ce_out !== 1'b0) $display("FAIL reset_ce_out: got %b want 0", bus.ce_out);
      else passed++;
      reset = 1'b0;
      clear_log();
      for (int k = 0; k < 20; k++) cyc(1'b0, 1'b1);
      total++;
      if (outs.size() !== 0) $display("FAIL reset_idle_ce: got %0d pulses want 0", outs.size());
      else passed++;
      total++;
      if (bus.filter_out !== '0) $display("FAIL reset_idle_hold: got %0d want 0", bus.filter_out);
      else passed++;
   endtask

   task automatic test_dc_ones();
      pulse_reset(1'b0);
      clear_log();
      feed(448, 0, 1'b0);
      check_outs("ones", 4, G);
      total++;
      if (out_edge.size() < 1 || out_edge[0] !== 256)
         $display("FAIL ones_first_edge: got %0d want 256", out_edge.size() < 1 ? -1 : out_edge[0]);
      else passed++;
      for (int i = 1; i < 4; i++) begin
         total++;
         if (i >= out_edge.size() || out_edge[i] - out_edge[i-1] !== 64)
            $display("FAIL ones_spacing[%0d]: got %0d want 64", i,
                     i >= out_edge.size() ? -1 : out_edge[i] - out_edge[i-1]);
         else passed++;
      end
   endtask

   task automatic test_dc_zeros();
      pulse_reset(1'b0);
      clear_log();
      feed(448, 1, 1'b0);
      check_outs("zeros", 4, -G);
   endtask

   task automatic test_alternating();
      pulse_reset(1'b0);
      clear_log();
      feed(448, 2, 1'b0);
      check_outs("alt", 4, 0);
   endtask

   task automatic run_step(input string name, input bit gated);
      pulse_reset(1'b0);
      clear_log();
      feed(320, 1, gated);
      feed(512, 0, gated);
      total++;
      if (outs.size() !== 10) $display("FAIL %s_count: got %0d want 10", name, outs.size());
      else passed++;
      for (int i = 0; i < 10; i++) begin
         total++;
         if (i >= outs.size()) $display("FAIL %s_val[%0d]: got none want %0d", name, i, step_exp[i]);
         else if (outs[i] !== step_exp[i])
            $display("FAIL %s_val[%0d]: got %0d want %0d", name, i, outs[i], step_exp[i]);
         else passed++;
      end
      total++;
      if (frozen_err !== 0) $display("FAIL %s_ce_frozen: got %0d want 0", name, frozen_err);
      else passed++;
      total++;
      if (width_err !== 0) $display("FAIL %s_ce_width: got %0d want 0", name, width_err);
      else passed++;
   endtask

   task automatic test_step();
      run_step("step", 1'b0);
   endtask

   task automatic test_gated();
      run_step("gated", 1'b1);
   endtask

   task automatic test_reset_midframe();
      pulse_reset(1'b0);
      clear_log();
      feed(448 + 37, 0, 1'b0);
      pulse_reset(1'b1);
      total++;
      if (bus.filter_out !== '0 || bus.ce_out !== 1'b0)
         $display("FAIL midreset_outputs: got %0d/%b want 0/0", bus.filter_out, bus.ce_out);
      else passed++;
      clear_log();
      feed(256, 0, 1'b0);
      check_outs("midreset", 1, G);
      total++;
      if (out_edge.size() < 1 || out_edge[0] !== 256)
         $display("FAIL midreset_first_edge: got %0d want 256", out_edge.size() < 1 ? -1 : out_edge[0]);
      else passed++;

      // Bring dcnt to 63 so the reset edge coincides with a strobe.
      feed(63, 0, 1'b0);
      pulse_reset(1'b1);
      total++;
      if (bus.filter_out !== '0 || bus.ce_out !== 1'b0)
         $display("FAIL strobereset_outputs: got %0d/%b want 0/0", bus.filter_out, bus.ce_out);
      else passed++;
      clear_log();
      for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1);
      feed(255, 0, 1'b0);
      total++;
      if (outs.size() !== 0) $display("FAIL strobereset_early_ce: got %0d pulses want 0", outs.size());
      else passed++;
      feed(1, 0, 1'b0);
      check_outs("strobereset", 1, G);
      total++;
      if (out_edge.size() < 1 || out_edge[0] !== 256)
         $display("FAIL strobereset_first_edge: got %0d want 256", out_edge.size() < 1 ? -1 : out_edge[0]);
      else passed++;
   endtask

   initial begin
      reset          = 1'b1;
      bus.clk_enable = 1'b0;
      bus.bit_in     = 1'b0;
      clear_log();
      ce_prev = 1'b0;
      last_en = 1'b0;
      test_reset();
      test_dc_ones();
      test_dc_zeros();
      test_alternating();
      test_step();
      test_gated();
      test_reset_midframe();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
